// File: rtl/hdc_pkg.sv
// Shared constants, sample array type and state encoding for the HDC dataset sequencer.
package hdc_pkg;

    localparam int FEATURE_COUNT             = 617;
    localparam int TRAINING_DATAPOINTS_COUNT = 6238;
    localparam int TESTING_DATAPOINTS_COUNT  = 1559;
    localparam int CLASS_COUNT               = 26;
    localparam int TIMER_W                   = 9;

    typedef logic [15:0] sample_t [0:FEATURE_COUNT-1];

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_FLUSH,
        S_TRAIN_FIN,
        S_BINARIZE,
        S_TEST_FIN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/hdc_seq_timer.sv
// Loadable down-counter used for every wait window of the sequencer; holds while en_i is low.
module hdc_seq_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hdc_dataset_sequencer.sv
// Drives the one-shot HDC top through a full train+test pass from a sample memory.
// Optional result latch: define HDC_SEQ_RESULT_LATCH_EN.
//   state     | meaning
//   IDLE      | waiting for go
//   FETCH     | read strobe for the current sample (also last gap cycle)
//   ISSUE     | new sample on input_values, start_mapping pulse
//   GAP       | spacing between start pulses
//   FLUSH     | drain time after the last sample of a phase
//   TRAIN_FIN | training_dataset_finished pulse
//   BINARIZE  | wait for the HDC top to binarize class vectors
//   TEST_FIN  | testing_dataset_finished pulse
//   DONE      | done pulse, back to IDLE
module hdc_dataset_sequencer #(
    parameter int FEATURE_COUNT             = hdc_pkg::FEATURE_COUNT,
    parameter int TRAINING_DATAPOINTS_COUNT = hdc_pkg::TRAINING_DATAPOINTS_COUNT,
    parameter int TESTING_DATAPOINTS_COUNT  = hdc_pkg::TESTING_DATAPOINTS_COUNT,
    parameter int ADDR_W                    = 13,
    parameter int MAP_GAP                   = 12,
    parameter int FLUSH_WAIT                = 23,
    parameter int BINARIZE_WAIT             = 259
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic                        go,
    output logic                        sample_rd_en,
    output logic [ADDR_W-1:0]           sample_rd_addr,
    input  logic [FEATURE_COUNT*16-1:0] sample_rd_data,
    input  logic [4:0]                  sample_rd_label,
    output logic                        start_mapping,
    output logic [15:0]                 input_values [0:FEATURE_COUNT-1],
    output logic [4:0]                  class_select_bits,
    output logic                        training_dataset_finished,
    output logic                        testing_dataset_finished,
    input  logic                        oneshot_hdc_done,
    input  logic [10:0]                 number_of_correct_inferences,
    output logic                        busy,
    output logic                        done,
    output logic [10:0]                 result_count,
    output logic                        result_valid
);

    import hdc_pkg::*;

    localparam logic [ADDR_W-1:0]  TRAIN_LAST    = ADDR_W'(TRAINING_DATAPOINTS_COUNT - 1);
    localparam logic [ADDR_W-1:0]  TEST_LAST     = ADDR_W'(TESTING_DATAPOINTS_COUNT - 1);
    // A wait state lasting N cycles is loaded with N-1.
    localparam logic [TIMER_W-1:0] GAP_LOAD      = TIMER_W'(MAP_GAP - 3);
    localparam logic [TIMER_W-1:0] LAST_GAP_LOAD = TIMER_W'(MAP_GAP - 2);
    localparam logic [TIMER_W-1:0] FLUSH_LOAD    = TIMER_W'(FLUSH_WAIT - 1);
    localparam logic [TIMER_W-1:0] BIN_LOAD      = TIMER_W'(BINARIZE_WAIT - 2);

    seq_state_e          state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                test_phase_q;
    logic                rd_en_q;
    logic                start_q;
    logic                train_fin_q;
    logic                test_fin_q;
    logic                done_q;
    logic                busy_q;
    logic [4:0]          class_q;
    logic [15:0]         values_q [0:FEATURE_COUNT-1];

    logic                go_accept;
    logic                last_sample;
    logic                tmr_load;
    logic                tmr_zero;
    logic [TIMER_W-1:0]  tmr_val;

    assign go_accept   = en && go && (state_q == S_IDLE);
    assign last_sample = (cnt_q == (test_phase_q ? TEST_LAST : TRAIN_LAST));

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        case (state_q)
            S_ISSUE: begin
                tmr_load = 1'b1;
                tmr_val  = last_sample ? LAST_GAP_LOAD : GAP_LOAD;
            end
            S_GAP: begin
                if (tmr_zero && last_sample) begin
                    tmr_load = 1'b1;
                    tmr_val  = FLUSH_LOAD;
                end
            end
            S_TRAIN_FIN: begin
                tmr_load = 1'b1;
                tmr_val  = BIN_LOAD;
            end
            default: ;
        endcase
    end

    hdc_seq_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .nrst       (nrst),
        .en_i       (en),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            test_phase_q <= 1'b0;
            rd_en_q      <= 1'b0;
            start_q      <= 1'b0;
            train_fin_q  <= 1'b0;
            test_fin_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            class_q      <= '0;
            for (int i = 0; i < FEATURE_COUNT; i++) begin
                values_q[i] <= '0;
            end
        end else if (!en) begin
            rd_en_q     <= 1'b0;
            start_q     <= 1'b0;
            train_fin_q <= 1'b0;
            test_fin_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            start_q     <= 1'b0;
            train_fin_q <= 1'b0;
            test_fin_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_accept) begin
                        state_q      <= S_FETCH;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        test_phase_q <= 1'b0;
                        busy_q       <= 1'b1;
                        rd_en_q      <= 1'b1;
                    end
                end
                // Memory data is valid on the edge that ends the FETCH cycle.
                S_FETCH: begin
                    state_q <= S_ISSUE;
                    start_q <= 1'b1;
                    class_q <= sample_rd_label;
                    for (int i = 0; i < FEATURE_COUNT; i++) begin
                        values_q[i] <= sample_rd_data[(FEATURE_COUNT-1-i)*16 +: 16];
                    end
                end
                S_ISSUE: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (tmr_zero) begin
                        if (last_sample) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_FETCH;
                            idx_q   <= idx_q + 1'b1;
                            cnt_q   <= cnt_q + 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (tmr_zero) begin
                        if (test_phase_q) begin
                            state_q    <= S_TEST_FIN;
                            test_fin_q <= 1'b1;
                        end else begin
                            state_q     <= S_TRAIN_FIN;
                            train_fin_q <= 1'b1;
                        end
                    end
                end
                S_TRAIN_FIN: begin
                    state_q <= S_BINARIZE;
                end
                S_BINARIZE: begin
                    if (tmr_zero) begin
                        state_q      <= S_FETCH;
                        idx_q        <= idx_q + 1'b1;
                        cnt_q        <= '0;
                        test_phase_q <= 1'b1;
                        rd_en_q      <= 1'b1;
                    end
                end
                S_TEST_FIN: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sample_rd_en              = rd_en_q;
    assign sample_rd_addr            = idx_q;
    assign start_mapping             = start_q;
    assign input_values              = values_q;
    assign class_select_bits         = class_q;
    assign training_dataset_finished = train_fin_q;
    assign testing_dataset_finished  = test_fin_q;
    assign busy                      = busy_q;
    assign done                      = done_q;

`ifdef HDC_SEQ_RESULT_LATCH_EN
    logic        hdc_done_q;
    logic [10:0] result_count_q;
    logic        result_valid_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hdc_done_q     <= 1'b0;
            result_count_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            hdc_done_q <= oneshot_hdc_done;
            if (go_accept) begin
                result_valid_q <= 1'b0;
            end else if (oneshot_hdc_done && !hdc_done_q && (busy_q || state_q == S_DONE)) begin
                result_count_q <= number_of_correct_inferences;
                result_valid_q <= 1'b1;
            end
        end
    end

    assign result_count = result_count_q;
    assign result_valid = result_valid_q;
`else
    logic unused_result_inputs;
    assign unused_result_inputs = ^{oneshot_hdc_done, number_of_correct_inferences};
    assign result_count         = '0;
    assign result_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_hdc_dataset_sequencer.sv
// Scoreboard bench for hdc_dataset_sequencer with a reduced dataset (4 features, 3 train, 2 test).
module tb_hdc_dataset_sequencer;

    localparam int FC     = 4;
    localparam int TRAIN  = 3;
    localparam int TEST   = 2;
    localparam int ADDR_W = 13;

    localparam int K_RD    = 0;
    localparam int K_START = 1;
    localparam int K_TRF   = 2;
    localparam int K_TEF   = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    logic                clk = 1'b0;
    logic                nrst;
    logic                en;
    logic                go;
    logic                sample_rd_en;
    logic [ADDR_W-1:0]   sample_rd_addr;
    logic [FC*16-1:0]    sample_rd_data;
    logic [4:0]          sample_rd_label;
    logic                start_mapping;
    logic [15:0]         input_values [0:FC-1];
    logic [4:0]          class_select_bits;
    logic                training_dataset_finished;
    logic                testing_dataset_finished;
    logic                oneshot_hdc_done;
    logic [10:0]         number_of_correct_inferences;
    logic                busy;
    logic                done;
    logic [10:0]         result_count;
    logic                result_valid;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    int  hold_addr = 0;
    bit  hold_valid = 1'b0;
    int  g_a, g_b, g_c, g_d;

    hdc_dataset_sequencer #(
        .FEATURE_COUNT             (FC),
        .TRAINING_DATAPOINTS_COUNT (TRAIN),
        .TESTING_DATAPOINTS_COUNT  (TEST),
        .ADDR_W                    (ADDR_W),
        .MAP_GAP                   (12),
        .FLUSH_WAIT                (23),
        .BINARIZE_WAIT             (259)
    ) dut (
        .clk                          (clk),
        .nrst                         (nrst),
        .en                           (en),
        .go                           (go),
        .sample_rd_en                 (sample_rd_en),
        .sample_rd_addr               (sample_rd_addr),
        .sample_rd_data               (sample_rd_data),
        .sample_rd_label              (sample_rd_label),
        .start_mapping                (start_mapping),
        .input_values                 (input_values),
        .class_select_bits            (class_select_bits),
        .training_dataset_finished    (training_dataset_finished),
        .testing_dataset_finished     (testing_dataset_finished),
        .oneshot_hdc_done             (oneshot_hdc_done),
        .number_of_correct_inferences (number_of_correct_inferences),
        .busy                         (busy),
        .done                         (done),
        .result_count                 (result_count),
        .result_valid                 (result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: word i of sample a is a+i (word 0 in the top bits), label a mod 26.
    always_comb begin
        sample_rd_data = '0;
        for (int i = 0; i < FC; i++) begin
            sample_rd_data[(FC-1-i)*16 +: 16] = 16'(int'(sample_rd_addr) + i);
        end
        sample_rd_label = 5'(int'(sample_rd_addr) % 26);
    end

    function automatic int exp_val(input int a, input int i);
        return (a + i) & 16'hFFFF;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input int k, input int a);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    // d shifts every event after the first start pulse; full=0 stops after the third start.
    task automatic push_pass(input int b, input int d, input bit full);
        push(b + 1, K_RD, 0);
        push(b + 2, K_START, 0);
        push(b + 13 + d, K_RD, 1);
        push(b + 14 + d, K_START, 1);
        push(b + 25 + d, K_RD, 2);
        push(b + 26 + d, K_START, 2);
        if (full) begin
            push(b + 61 + d, K_TRF, 0);
            push(b + 320 + d, K_RD, 3);
            push(b + 321 + d, K_START, 3);
            push(b + 332 + d, K_RD, 4);
            push(b + 333 + d, K_START, 4);
            push(b + 368 + d, K_TEF, 0);
            push(b + 369 + d, K_DONE, 0);
        end
    endtask

    task automatic take_ev(input int kind, output int addr);
        ev_t e;
        addr = -1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse at cycle %0d: actual kind=%0d required no pulse", cyc, kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            addr = e.addr;
        end
    endtask

    always @(negedge clk) begin
        int a;
        if (!nrst) hold_valid = 1'b0;
        if (sample_rd_en) begin
            take_ev(K_RD, a);
            if (a >= 0) chk("rd_addr", int'(sample_rd_addr), a);
        end
        if (start_mapping) begin
            take_ev(K_START, a);
            if (a >= 0) begin
                for (int i = 0; i < FC; i++) chk("start_value", int'(input_values[i]), exp_val(a, i));
                chk("start_class", int'(class_select_bits), a % 26);
                hold_addr  = a;
                hold_valid = 1'b1;
            end
        end else if (hold_valid) begin
            for (int i = 0; i < FC; i++) chk("hold_value", int'(input_values[i]), exp_val(hold_addr, i));
            chk("hold_class", int'(class_select_bits), hold_addr % 26);
        end
        if (training_dataset_finished) take_ev(K_TRF, a);
        if (testing_dataset_finished)  take_ev(K_TEF, a);
        if (done)                      take_ev(K_DONE, a);
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_go(input int c);
        goto(c);
        go = 1'b1;
        goto(c + 1);
        go = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, int'(sample_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(sample_rd_addr), 0);
        chk({tag, "_start"}, int'(start_mapping), 0);
        chk({tag, "_class"}, int'(class_select_bits), 0);
        chk({tag, "_train_fin"}, int'(training_dataset_finished), 0);
        chk({tag, "_test_fin"}, int'(testing_dataset_finished), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result_count"}, int'(result_count), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        for (int i = 0; i < FC; i++) chk({tag, "_value"}, int'(input_values[i]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        en   = 1'b1;
        go   = 1'b0;
        oneshot_hdc_done = 1'b0;
        number_of_correct_inferences = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Run A: nominal pass, a second go while busy, result latch while busy.
        g_a = cyc + 5;
        push_pass(g_a, 0, 1'b1);
        do_go(g_a);
        chk("busy_after_go", int'(busy), 1);
        do_go(g_a + 50);
        goto(g_a + 100);
        oneshot_hdc_done = 1'b1;
        number_of_correct_inferences = 11'd1234;
        goto(g_a + 101);
`ifdef HDC_SEQ_RESULT_LATCH_EN
        chk("result_count_latched", int'(result_count), 1234);
        chk("result_valid_set", int'(result_valid), 1);
`else
        chk("result_count_tied", int'(result_count), 0);
        chk("result_valid_tied", int'(result_valid), 0);
`endif
        goto(g_a + 110);
        oneshot_hdc_done = 1'b0;
        goto(g_a + 368);
        chk("busy_before_done", int'(busy), 1);
        goto(g_a + 369);
        chk("busy_in_done", int'(busy), 0);

        // Run B: en low for five cycles inside the first gap.
        g_b = g_a + 380;
        push_pass(g_b, 5, 1'b1);
        goto(g_b);
`ifdef HDC_SEQ_RESULT_LATCH_EN
        chk("result_valid_held", int'(result_valid), 1);
`else
        chk("result_valid_idle", int'(result_valid), 0);
`endif
        do_go(g_b);
        chk("result_valid_cleared", int'(result_valid), 0);
        goto(g_b + 10);
        en = 1'b0;
        goto(g_b + 12);
        chk("en_low_addr_hold", int'(sample_rd_addr), 0);
        chk("en_low_busy_hold", int'(busy), 1);
        goto(g_b + 15);
        en = 1'b1;
        goto(g_b + 380);

        // Run C: asynchronous reset mid-pass, then a fresh pass from address 0.
        g_c = cyc + 2;
        push_pass(g_c, 0, 1'b0);
        do_go(g_c);
        goto(g_c + 40);
        #2;
        nrst = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("queue_empty_at_reset", exp_q.size(), 0);
        goto(g_c + 45);
        nrst = 1'b1;

        g_d = g_c + 50;
        push_pass(g_d, 0, 1'b1);
        do_go(g_d);
        goto(g_d + 375);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
